// File: rtl/ime_sad_ctrl.sv
// Full-search integer-motion-estimation SAD sequencer: issues 16-row comparisons per candidate, accumulates row SADs, keeps the best MV.
// Optional build macro IME_EARLY_TERM_EN: abort a candidate once its partial SAD reaches the current best.
module ime_sad_ctrl #(
    parameter int RANGE    = 8,
    parameter int PIPE     = 2,
    parameter int ROWSAD_W = 12,
    parameter int SAD_W    = 16,
    parameter int MV_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                issue,
    output logic                pe_roll,
    output logic [3:0]          cur_row,
    output logic [MV_W-1:0]     ref_x,
    output logic [MV_W-1:0]     ref_y,
    input  logic [ROWSAD_W-1:0] row_sad,
    output logic [MV_W-1:0]     best_mvx,
    output logic [MV_W-1:0]     best_mvy,
    output logic [SAD_W-1:0]    best_sad
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [MV_W-1:0] MV_MIN   = MV_W'(-RANGE);
    localparam logic [MV_W-1:0] MV_MAX   = MV_W'(RANGE - 1);
    localparam logic [MV_W-1:0] MV_ONE   = MV_W'(1);
    localparam int              DRN_W    = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE - 1);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
    localparam int              EXT_W    = SAD_W - ROWSAD_W;

    state_e            state_q, state_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic              issue_q, issue_d;
    logic              pe_roll_q, pe_roll_d;
    logic [3:0]        row_q, row_d;
    logic [MV_W-1:0]   x_q, x_d, y_q, y_d;
    logic              tag_q, tag_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SAD_W-1:0]  acc_q, acc_d;
    logic [SAD_W-1:0]  best_sad_q, best_sad_d;
    logic [MV_W-1:0]   best_x_q, best_x_d, best_y_q, best_y_d;

    // In-flight issue tracking; index PIPE-1 is the entry whose row_sad is present now
    logic [PIPE-1:0]   pv_q, pv_d;
    logic [PIPE-1:0]   pfirst_q, pfirst_d;
    logic [PIPE-1:0]   plast_q, plast_d;
    logic [PIPE-1:0]   ptag_q, ptag_d;
    logic [MV_W-1:0]   px_q [PIPE];
    logic [MV_W-1:0]   px_d [PIPE];
    logic [MV_W-1:0]   py_q [PIPE];
    logic [MV_W-1:0]   py_d [PIPE];

    logic [SAD_W-1:0]  row_ext_s;
    logic [SAD_W-1:0]  sum_s;
    logic              head_v_s;
    logic              head_tag_s;
    logic              abort_s;
    logic              cut_s;
    logic              cand_last_s;

    assign row_ext_s   = {{EXT_W{1'b0}}, row_sad};
    assign cand_last_s = (x_q == MV_MAX) && (y_q == MV_MAX);

    // Head-of-pipe result: running candidate sum and early-termination decision
    always_comb begin
        head_v_s   = pv_q[PIPE-1];
        head_tag_s = ptag_q[PIPE-1];
        if (pfirst_q[PIPE-1]) begin
            sum_s = row_ext_s;
        end else begin
            sum_s = acc_q + row_ext_s;
        end
`ifdef IME_EARLY_TERM_EN
        abort_s = head_v_s && !plast_q[PIPE-1] && (sum_s >= best_sad_q);
`else
        abort_s = 1'b0;
`endif
        cut_s = abort_s && issue_q && (tag_q == head_tag_s);
    end

    // Next-state, issue pointer, tracking pipeline and best-candidate update
    always_comb begin
        state_d    = state_q;
        drn_d      = drn_q;
        issue_d    = 1'b0;
        pe_roll_d  = 1'b0;
        row_d      = row_q;
        x_d        = x_q;
        y_d        = y_q;
        tag_d      = tag_q;
        acc_d      = acc_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;

        pv_d[0]     = issue_q && !cut_s;
        pfirst_d[0] = (row_q == 4'd0);
        plast_d[0]  = (row_q == 4'd15);
        ptag_d[0]   = tag_q;
        px_d[0]     = x_q;
        py_d[0]     = y_q;
        for (int k = 1; k < PIPE; k++) begin
            pv_d[k]     = pv_q[k-1] && !(abort_s && (ptag_q[k-1] == head_tag_s));
            pfirst_d[k] = pfirst_q[k-1];
            plast_d[k]  = plast_q[k-1];
            ptag_d[k]   = ptag_q[k-1];
            px_d[k]     = px_q[k-1];
            py_d[k]     = py_q[k-1];
        end

        if (head_v_s) begin
            acc_d = sum_s;
            // Strict compare keeps the earliest raster candidate on ties
            if (plast_q[PIPE-1] && (sum_s < best_sad_q)) begin
                best_sad_d = sum_s;
                best_x_d   = px_q[PIPE-1];
                best_y_d   = py_q[PIPE-1];
            end else begin
                best_sad_d = best_sad_q;
            end
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    issue_d    = 1'b1;
                    pe_roll_d  = 1'b1;
                    row_d      = 4'd0;
                    x_d        = MV_MIN;
                    y_d        = MV_MIN;
                    tag_d      = 1'b0;
                    acc_d      = {SAD_W{1'b0}};
                    best_sad_d = {SAD_W{1'b1}};
                    best_x_d   = {MV_W{1'b0}};
                    best_y_d   = {MV_W{1'b0}};
                    pv_d       = {PIPE{1'b0}};
                    drn_d      = {DRN_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (cut_s || (row_q == 4'd15)) begin
                    if (cand_last_s) begin
                        state_d = S_DRAIN;
                        drn_d   = {DRN_W{1'b0}};
                    end else begin
                        issue_d   = 1'b1;
                        pe_roll_d = 1'b1;
                        row_d     = 4'd0;
                        tag_d     = ~tag_q;
                        if (x_q == MV_MAX) begin
                            x_d = MV_MIN;
                            y_d = y_q + MV_ONE;
                        end else begin
                            x_d = x_q + MV_ONE;
                        end
                    end
                end else begin
                    issue_d = 1'b1;
                    row_d   = row_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + DRN_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            drn_q      <= {DRN_W{1'b0}};
            issue_q    <= 1'b0;
            pe_roll_q  <= 1'b0;
            row_q      <= 4'd0;
            x_q        <= {MV_W{1'b0}};
            y_q        <= {MV_W{1'b0}};
            tag_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= {SAD_W{1'b0}};
            best_sad_q <= {SAD_W{1'b1}};
            best_x_q   <= {MV_W{1'b0}};
            best_y_q   <= {MV_W{1'b0}};
            pv_q       <= {PIPE{1'b0}};
            pfirst_q   <= {PIPE{1'b0}};
            plast_q    <= {PIPE{1'b0}};
            ptag_q     <= {PIPE{1'b0}};
            px_q       <= '{default: '0};
            py_q       <= '{default: '0};
        end else begin
            state_q    <= state_d;
            drn_q      <= drn_d;
            issue_q    <= issue_d;
            pe_roll_q  <= pe_roll_d;
            row_q      <= row_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            acc_q      <= acc_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            pv_q       <= pv_d;
            pfirst_q   <= pfirst_d;
            plast_q    <= plast_d;
            ptag_q     <= ptag_d;
            px_q       <= px_d;
            py_q       <= py_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign issue    = issue_q;
    assign pe_roll  = pe_roll_q;
    assign cur_row  = row_q;
    assign ref_x    = x_q;
    assign ref_y    = y_q;
    assign best_mvx = best_x_q;
    assign best_mvy = best_y_q;
    assign best_sad = best_sad_q;

endmodule

// File: tb/tb_ime_sad_ctrl.sv
// Directed self-checking bench for ime_sad_ctrl with default parameters; row_sad is supplied PIPE cycles after each issue.
module tb_ime_sad_ctrl;

    localparam int PIPE = 2;
    localparam logic [4:0] MV_M8 = 5'h18;
    localparam logic [4:0] MV_M7 = 5'h19;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        issue;
    logic        pe_roll;
    logic [3:0]  cur_row;
    logic [4:0]  ref_x;
    logic [4:0]  ref_y;
    logic [11:0] row_sad;
    logic [4:0]  best_mvx;
    logic [4:0]  best_mvy;
    logic [15:0] best_sad;

    int n_chk;
    int n_pass;

    // Issue history: index 0 is this cycle, index PIPE is PIPE cycles ago
    logic hv [0:PIPE];
    int   hx [0:PIPE];
    int   hy [0:PIPE];

    // Snapshots at cycles 1, 16, 17 of the latest search
    logic       sn_issue [3];
    logic       sn_roll  [3];
    logic       sn_busy  [3];
    logic [3:0] sn_row   [3];
    logic [4:0] sn_x     [3];
    logic [4:0] sn_y     [3];

    ime_sad_ctrl #(
        .RANGE(8), .PIPE(PIPE), .ROWSAD_W(12), .SAD_W(16), .MV_W(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .issue(issue), .pe_roll(pe_roll), .cur_row(cur_row),
        .ref_x(ref_x), .ref_y(ref_y), .row_sad(row_sad),
        .best_mvx(best_mvx), .best_mvy(best_mvy), .best_sad(best_sad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] sad_of(input int pat, input int x, input int y);
        case (pat)
            0:       return 12'd100;
            1:       return (x == 3 && y == -2) ? 12'd10 : 12'd255;
            2:       return ((x == -1 || x == 5) && y == 0) ? 12'd10 : 12'd255;
            3:       return (x == -8 && y == -8) ? 12'd0 : 12'd4080;
            default: return 12'd0;
        endcase
    endfunction

    // Drives one search from a start pulse; returns at the done cycle, at stop_at, or after the cycle budget (done_cyc = -1)
    task automatic run_search(input int pat, input int stop_at, input bit glitch,
                              output int done_cyc, output int n_issue);
        int cyc;
        int si;
        done_cyc = -1;
        n_issue  = 0;
        cyc      = 0;
        for (int k = 0; k <= PIPE; k++) begin
            hv[k] = 1'b0;
            hx[k] = 0;
            hy[k] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        while (cyc < 6000 && done_cyc < 0 && !(stop_at > 0 && cyc >= stop_at)) begin
            @(negedge clk);
            cyc++;
            start = (glitch && cyc == 100) ? 1'b1 : 1'b0;
            for (int k = PIPE; k > 0; k--) begin
                hv[k] = hv[k-1];
                hx[k] = hx[k-1];
                hy[k] = hy[k-1];
            end
            hv[0] = issue;
            hx[0] = $signed(ref_x);
            hy[0] = $signed(ref_y);
            row_sad = hv[PIPE] ? sad_of(pat, hx[PIPE], hy[PIPE]) : 12'hA5A;
            if (issue) n_issue++;
            if (done) done_cyc = cyc;
            if (cyc == 1 || cyc == 16 || cyc == 17) begin
                si = (cyc == 1) ? 0 : ((cyc == 16) ? 1 : 2);
                sn_issue[si] = issue;
                sn_roll[si]  = pe_roll;
                sn_busy[si]  = busy;
                sn_row[si]   = cur_row;
                sn_x[si]     = ref_x;
                sn_y[si]     = ref_y;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        row_sad = 12'd0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else n_pass++;
        n_chk++; if (issue !== 1'b0) $display("FAIL rst_issue: got %0b want 0", issue); else n_pass++;
        n_chk++; if (pe_roll !== 1'b0) $display("FAIL rst_pe_roll: got %0b want 0", pe_roll); else n_pass++;
        n_chk++; if (cur_row !== 4'd0) $display("FAIL rst_cur_row: got %0d want 0", cur_row); else n_pass++;
        n_chk++; if ({ref_x, ref_y} !== 10'd0) $display("FAIL rst_ref: got %h want 000", {ref_x, ref_y}); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== 10'd0) $display("FAIL rst_best_mv: got %h want 000", {best_mvx, best_mvy}); else n_pass++;
        n_chk++; if (best_sad !== 16'hFFFF) $display("FAIL rst_best_sad: got %h want ffff", best_sad); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_uniform();
        int dc, ni;
        run_search(0, 0, 1'b0, dc, ni);
        n_chk++; if (dc !== 4099) $display("FAIL uni_done_cycle: got %0d want 4099", dc); else n_pass++;
        n_chk++; if (ni !== 4096) $display("FAIL uni_issue_count: got %0d want 4096", ni); else n_pass++;
        n_chk++; if (best_sad !== 16'd1600) $display("FAIL uni_best_sad: got %0d want 1600", best_sad); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== {MV_M8, MV_M8}) $display("FAIL uni_best_mv: got %h want %h", {best_mvx, best_mvy}, {MV_M8, MV_M8}); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL uni_busy_at_done: got %0b want 0", busy); else n_pass++;
        n_chk++; if ({sn_issue[0], sn_roll[0], sn_busy[0]} !== 3'b111) $display("FAIL c1_issue_roll_busy: got %b want 111", {sn_issue[0], sn_roll[0], sn_busy[0]}); else n_pass++;
        n_chk++; if ({sn_row[0], sn_x[0], sn_y[0]} !== {4'd0, MV_M8, MV_M8}) $display("FAIL c1_row_ref: got %h want %h", {sn_row[0], sn_x[0], sn_y[0]}, {4'd0, MV_M8, MV_M8}); else n_pass++;
        n_chk++; if ({sn_issue[1], sn_roll[1], sn_row[1]} !== {1'b1, 1'b0, 4'd15}) $display("FAIL c16_row15: got %h want %h", {sn_issue[1], sn_roll[1], sn_row[1]}, {1'b1, 1'b0, 4'd15}); else n_pass++;
        n_chk++; if ({sn_roll[2], sn_row[2], sn_x[2], sn_y[2]} !== {1'b1, 4'd0, MV_M7, MV_M8}) $display("FAIL c17_next_cand: got %h want %h", {sn_roll[2], sn_row[2], sn_x[2], sn_y[2]}, {1'b1, 4'd0, MV_M7, MV_M8}); else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0) $display("FAIL uni_done_pulse: got %0b want 0", done); else n_pass++;
    endtask

    task automatic test_single_min();
        int dc, ni;
        run_search(1, 0, 1'b0, dc, ni);
        n_chk++; if (best_sad !== 16'd160) $display("FAIL min_best_sad: got %0d want 160", best_sad); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== {5'h03, 5'h1E}) $display("FAIL min_best_mv: got %h want %h", {best_mvx, best_mvy}, {5'h03, 5'h1E}); else n_pass++;
`ifdef IME_EARLY_TERM_EN
        n_chk++; if (!(dc > 0 && dc < 4099)) $display("FAIL min_done_cycle: got %0d want 1..4098", dc); else n_pass++;
`else
        n_chk++; if (dc !== 4099) $display("FAIL min_done_cycle: got %0d want 4099", dc); else n_pass++;
`endif
    endtask

    task automatic test_tie();
        int dc, ni;
        run_search(2, 0, 1'b0, dc, ni);
        n_chk++; if (best_sad !== 16'd160) $display("FAIL tie_best_sad: got %0d want 160", best_sad); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== {5'h1F, 5'h00}) $display("FAIL tie_best_mv: got %h want %h", {best_mvx, best_mvy}, {5'h1F, 5'h00}); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int dc, ni;
        run_search(0, 0, 1'b1, dc, ni);
        n_chk++; if (dc !== 4099) $display("FAIL ign_done_cycle: got %0d want 4099", dc); else n_pass++;
        n_chk++; if (ni !== 4096) $display("FAIL ign_issue_count: got %0d want 4096", ni); else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++; if ({done, busy, issue} !== 3'b000) $display("FAIL ign_after_done: got %b want 000", {done, busy, issue}); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if ({done, busy, issue} !== 3'b000) $display("FAIL ign_idle_hold: got %b want 000", {done, busy, issue}); else n_pass++;
        n_chk++; if (best_sad !== 16'd1600) $display("FAIL ign_best_sad: got %0d want 1600", best_sad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dc, ni;
        run_search(1, 0, 1'b0, dc, ni);
        n_chk++; if (best_sad !== 16'd160) $display("FAIL b2b_first_sad: got %0d want 160", best_sad); else n_pass++;
        run_search(2, 0, 1'b0, dc, ni);
        n_chk++; if ({sn_issue[0], sn_roll[0], sn_busy[0]} !== 3'b111) $display("FAIL b2b_reaccept: got %b want 111", {sn_issue[0], sn_roll[0], sn_busy[0]}); else n_pass++;
        n_chk++; if (dc <= 0) $display("FAIL b2b_second_done: got %0d want >0", dc); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== {5'h1F, 5'h00}) $display("FAIL b2b_second_mv: got %h want %h", {best_mvx, best_mvy}, {5'h1F, 5'h00}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dc, ni;
        run_search(1, 2000, 1'b0, dc, ni);
        rst = 1'b0;
        #1;
        n_chk++; if ({busy, done, issue, pe_roll, cur_row} !== 8'd0) $display("FAIL mid_rst_ctrl: got %h want 00", {busy, done, issue, pe_roll, cur_row}); else n_pass++;
        n_chk++; if ({ref_x, ref_y, best_mvx, best_mvy} !== 20'd0) $display("FAIL mid_rst_mv: got %h want 00000", {ref_x, ref_y, best_mvx, best_mvy}); else n_pass++;
        n_chk++; if (best_sad !== 16'hFFFF) $display("FAIL mid_rst_best_sad: got %h want ffff", best_sad); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        run_search(0, 0, 1'b0, dc, ni);
        n_chk++; if (dc !== 4099) $display("FAIL mid_rerun_done: got %0d want 4099", dc); else n_pass++;
        n_chk++; if (best_sad !== 16'd1600) $display("FAIL mid_rerun_sad: got %0d want 1600", best_sad); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== {MV_M8, MV_M8}) $display("FAIL mid_rerun_mv: got %h want %h", {best_mvx, best_mvy}, {MV_M8, MV_M8}); else n_pass++;
    endtask

    task automatic test_early_term();
        int dc, ni;
        run_search(3, 0, 1'b0, dc, ni);
        n_chk++; if (best_sad !== 16'd0) $display("FAIL et_best_sad: got %0d want 0", best_sad); else n_pass++;
        n_chk++; if ({best_mvx, best_mvy} !== {MV_M8, MV_M8}) $display("FAIL et_best_mv: got %h want %h", {best_mvx, best_mvy}, {MV_M8, MV_M8}); else n_pass++;
`ifdef IME_EARLY_TERM_EN
        n_chk++; if (!(dc > 0 && dc < 4099)) $display("FAIL et_done_cycle: got %0d want 1..4098", dc); else n_pass++;
        n_chk++; if (!(ni > 16 && ni < 4096)) $display("FAIL et_issue_count: got %0d want 17..4095", ni); else n_pass++;
`else
        n_chk++; if (dc !== 4099) $display("FAIL et_done_cycle: got %0d want 4099", dc); else n_pass++;
        n_chk++; if (ni !== 4096) $display("FAIL et_issue_count: got %0d want 4096", ni); else n_pass++;
`endif
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_uniform();
        test_single_min();
        test_tie();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ime_sad_ctrl.md
# ime_sad_ctrl

Sequencer for the integer-motion-estimation SAD datapath: a row of 16 absolute-difference processing elements plus an external adder tree. It walks a full-search window in raster order and issues one 16-pixel row comparison per cycle. It accumulates the returned row SADs per candidate and keeps the minimum-SAD motion vector. It sits between the macroblock/search-window buffers (driven through its row and offset outputs) and the mode-decision stage (which consumes best_mvx/best_mvy/best_sad on done).

## Interface
- RANGE, 8: search range; candidate offsets −RANGE..RANGE−1 in x and y (2·RANGE squared candidates).
- PIPE, 2: fixed latency in cycles from issue to row_sad valid at this block's input (≥1).
- ROWSAD_W, 12: row SAD width (16·255 = 4080).
- SAD_W, 16: accumulated candidate SAD width (256·255 = 65280).
- MV_W, 5: signed MV component width; must hold −RANGE..RANGE−1.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; honoured only in IDLE.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse; best_* valid from this cycle until the next accepted start.
- issue  out  1  row request valid to buffers/PE array.
- pe_roll  out  1  high with issue on row 0 of each candidate (PE array clears its stage).
- cur_row  out  4  macroblock row index 0..15 of the current issue.
- ref_x, ref_y  out  MV_W each  signed candidate offset of the current issue.
- row_sad  in  ROWSAD_W  row SAD; sampled exactly PIPE cycles after the matching issue.
- best_mvx, best_mvy  out  MV_W each  signed winning offset.
- best_sad  out  SAD_W  winning SAD.

## Operation
- States: IDLE → SCAN on start; SCAN → DRAIN after the last issue (row 15 of candidate (RANGE−1, RANGE−1)); DRAIN → DONE after PIPE cycles; DONE → IDLE unconditionally after 1 cycle.
- Scan order: ref_y outer, ref_x inner, both starting at −RANGE and incrementing; cur_row 0..15 innermost. Issues are back to back, with no bubbles between candidates.
- Issue tracking: an internal PIPE-deep shift register carries valid, last-row flag, candidate tag (1-bit parity), and offsets alongside each issue.
- Accumulation: the accumulator is loaded with row_sad on row 0 and adds row_sad on rows 1..15. Arithmetic is unsigned and zero-extended to SAD_W; it never saturates, because of the width rule.
- Compare: on the result for row 15, if the total is less than best_sad, update best_sad/best_mvx/best_mvy. The comparison is strict, so the first candidate in raster order wins ties.
- On accepted start: best_sad ← all ones, best_mv ← 0, accumulator cleared, in-flight valids cleared.
- start while busy or in DONE: ignored, with no effect on the search.
- rst low mid-search: all state returns to reset values immediately; in-flight results are lost.

## Timing
- Reset values: busy 0, done 0, issue 0, pe_roll 0, cur_row 0, ref_x/ref_y 0, best_mvx/best_mvy 0, best_sad all ones.
- Cycle 0: start sampled high in IDLE.
- Cycle 1: SCAN; issue=1, pe_roll=1, cur_row 0, offset (−RANGE, −RANGE).
- Full search without early termination: last issue at cycle 16·(2·RANGE)², done pulse at cycle 16·(2·RANGE)² + PIPE + 1. With defaults this is cycle 4099.
- best_* are registered and update on the cycle after the row-15 result is sampled. They are final when done is high.
- Reaccept: start is honoured in the cycle after done (back in IDLE).

## Configuration
- IME_EARLY_TERM_EN defined: if the running partial SAD, including the current row, is ≥ best_sad before row 15, the candidate is aborted. All in-flight entries carrying the aborted candidate's tag are squashed (valid cleared). If the issue pointer is still on that candidate, it jumps to row 0 of the next candidate on the following cycle, with pe_roll asserted. The result is identical to a full search; only the cycle count shrinks. If the aborted candidate is the last one, the state moves to DRAIN at once.
- Undefined: every candidate runs all 16 rows; the cycle count is exactly as given in Timing.

## Test plan
- Uniform row_sad=100 on all rows, defaults → best_sad 1600, best_mv (−8,−8) via first-tie rule, done at cycle 4099.
- row_sad=255 everywhere except candidate (3,−2), where row_sad=10 → best_sad 160, best_mv (3,−2).
- Two candidates tied at minimum, (−1,0) and (5,0) → best_mv (−1,0).
- start pulsed again during SCAN and in the DONE cycle → ignored; exactly one done per accepted start. Next start is accepted the cycle after done.
- rst low for 1 cycle at cycle 2000 → all outputs at reset values; a subsequent start yields a full, correct search.
- IME_EARLY_TERM_EN defined, row 0 SAD of candidate 0 = 0 with all others = 4080 → best_sad 0 at (−8,−8). Every later candidate is aborted after its first result, and done arrives well before cycle 4099. A golden model confirms an identical best_* to the macro-off build.
